gbt_link_supervisor: RTL and testbench

GBT_LINK_SUPERVISOR -- requirements
Module: gbt_link_supervisor

---
 rtl/MCPkg.sv | 15 +
 rtl/gbt_link_supervisor_pkg.sv | 14 +
 rtl/gbt_link_supervisor_if.sv | 9 +
 rtl/gbt_link_supervisor_los_filter.sv | 43 ++++
 rtl/gbt_link_supervisor.sv | 159 +++++++++++++++
 tb/tb_gbt_link_supervisor.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/MCPkg.sv
// State type and encodings of the GBT link supervisor FSM, shared with
// software-visible status decoding.
package MCPkg;

  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    GEN_RESET = 3'd1,
    WAIT_TX   = 3'd2,
    RX_RESET  = 3'd3,
    WAIT_RX   = 3'd4,
    LINK_UP   = 3'd5,
    BACKOFF   = 3'd6
  } t_gbt_sup_state;

endpackage

// File: rtl/gbt_link_supervisor_pkg.sv
// Shared widths and saturating-counter helpers for the GBT link supervisor.
package gbt_link_supervisor_pkg;

  localparam int TIMER_W = 24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gbt_link_supervisor_if.sv
// Raw and filtered SFP loss-of-signal pair passed between the supervisor
// and its LOS filter.
interface gbt_link_supervisor_if;
  logic los_raw;
  logic los_f;

  modport master (output los_raw, input los_f);
  modport slave  (input los_raw, output los_f);
endinterface

// File: rtl/gbt_link_supervisor_los_filter.sv
// Synchronises the asynchronous SFP LOS and debounces it: the filtered level
// flips only after G_LOS_FILTER consecutive samples at the opposite level.
module gbt_los_filter #(
  parameter int G_LOS_FILTER = 16
) (
  input  logic                  clk_ik,
  input  logic                  rst_ir,
  gbt_link_supervisor_if.slave  los_bus
);

  localparam int CW = $clog2(G_LOS_FILTER + 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          los_f_r;

  // Two-flop synchroniser; resets to "loss" so the link stays down until proven.
  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], los_bus.los_raw};
    end
  end

  // Run-length counter of samples disagreeing with the current filtered level.
  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      cnt_r   <= {CW{1'b0}};
      los_f_r <= 1'b1;
    end else if (sync_r[1] == los_f_r) begin
      cnt_r   <= {CW{1'b0}};
    end else if (cnt_r == CW'(G_LOS_FILTER - 1)) begin
      cnt_r   <= {CW{1'b0}};
      los_f_r <= ~los_f_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  assign los_bus.los_f = los_f_r;

endmodule

// File: rtl/gbt_link_supervisor.sv
// GBT link bring-up supervisor: sequences bank resets, watches TX/RX ready,
// LOS and RX error rate, and retries with a back-off after failures.
module gbt_link_supervisor
  import MCPkg::*;
  import gbt_link_supervisor_pkg::*;
#(
  parameter int G_RESET_CYCLES  = 40,
  parameter int G_TX_TIMEOUT    = 4_000_000,
  parameter int G_RX_TIMEOUT    = 4_000_000,
  parameter int G_BACKOFF       = 400_000,
  parameter int G_LOS_FILTER    = 16,
  parameter int G_ERR_THRESHOLD = 8,
  parameter int G_ERR_WINDOW    = 40_000
) (
  input  logic        clk_ik,
  input  logic        rst_ir,
  input  logic        enable_i,
  input  logic        sfp_los_i,
  input  logic        gbttx_ready_i,
  input  logic        gbtrx_ready_i,
  input  logic        link_ready_i,
  input  logic        rx_errordetected_i,
  input  logic        clr_cnt_i,
  output logic        general_reset_o,
  output logic        manual_reset_rx_o,
  output logic        sfp_txdisable_o,
  output logic        link_up_o,
  output logic [2:0]  state_o,
  output logic [7:0]  retry_cnt_o,
  output logic [15:0] error_cnt_o
);

  t_gbt_sup_state     state_r, state_n;
  logic [TIMER_W-1:0] timer_r, timer_n;
  logic [15:0]        win_r, win_n, win_sum_s;
  logic [7:0]         retry_n;
  logic [15:0]        errc_n;
  logic               los_f_s, tmo_s, err_s, err_hit_s, retry_inc_s;

  gbt_link_supervisor_if los_bus ();
  assign los_bus.los_raw = sfp_los_i;
  assign los_f_s         = los_bus.los_f;

  gbt_los_filter #(.G_LOS_FILTER(G_LOS_FILTER)) u_los_filter (
    .clk_ik  (clk_ik),
    .rst_ir  (rst_ir),
    .los_bus (los_bus)
  );

  // In LINK_UP the shared timer paces the error window instead of a timeout.
  function automatic logic [TIMER_W-1:0] reload(input t_gbt_sup_state s);
    logic [TIMER_W-1:0] v;
    case (s)
      GEN_RESET, RX_RESET: v = TIMER_W'(G_RESET_CYCLES - 1);
      WAIT_TX:             v = TIMER_W'(G_TX_TIMEOUT - 1);
      WAIT_RX:             v = TIMER_W'(G_RX_TIMEOUT - 1);
      LINK_UP:             v = TIMER_W'(G_ERR_WINDOW - 1);
      BACKOFF:             v = TIMER_W'(G_BACKOFF - 1);
      default:             v = {TIMER_W{1'b0}};
    endcase
    return v;
  endfunction

  // Next state, shared timer, error window and counter updates.
  always_comb begin
    state_n   = state_r;
    tmo_s     = (timer_r == {TIMER_W{1'b0}});
    err_s     = (state_r == LINK_UP) && rx_errordetected_i;
    win_sum_s = win_r + {15'd0, err_s};
    err_hit_s = (win_sum_s >= 16'(G_ERR_THRESHOLD));

    if (!enable_i) begin
      state_n = DISABLED;
    end else begin
      case (state_r)
        DISABLED:  if (!los_f_s) state_n = GEN_RESET; else state_n = DISABLED;
        GEN_RESET: if (los_f_s) state_n = BACKOFF;
                   else if (tmo_s) state_n = WAIT_TX;
                   else state_n = GEN_RESET;
        WAIT_TX:   if (los_f_s || tmo_s) state_n = BACKOFF;
                   else if (gbttx_ready_i) state_n = RX_RESET;
                   else state_n = WAIT_TX;
        RX_RESET:  if (los_f_s) state_n = BACKOFF;
                   else if (tmo_s) state_n = WAIT_RX;
                   else state_n = RX_RESET;
        WAIT_RX:   if (los_f_s || tmo_s) state_n = BACKOFF;
                   else if (gbtrx_ready_i && link_ready_i) state_n = LINK_UP;
                   else state_n = WAIT_RX;
        LINK_UP:   if (los_f_s) state_n = BACKOFF;
                   else if (!gbtrx_ready_i || err_hit_s) state_n = RX_RESET;
                   else state_n = LINK_UP;
        BACKOFF:   if (tmo_s) state_n = GEN_RESET; else state_n = BACKOFF;
        default:   state_n = DISABLED;
      endcase
    end

    if (state_n != state_r) begin
      timer_n = reload(state_n);
    end else if (tmo_s && (state_r == LINK_UP)) begin
      timer_n = reload(LINK_UP);
    end else if (tmo_s) begin
      timer_n = timer_r;
    end else begin
      timer_n = timer_r - TIMER_W'(1);
    end

    if ((state_n != LINK_UP) || tmo_s) begin
      win_n = 16'd0;
    end else begin
      win_n = win_sum_s;
    end

    retry_inc_s = ((state_n == BACKOFF) && (state_r != BACKOFF)) ||
                  ((state_r == LINK_UP) && (state_n == RX_RESET));

    if (clr_cnt_i) begin
      retry_n = 8'd0;
      errc_n  = 16'd0;
    end else begin
      retry_n = retry_inc_s ? sat_inc8(retry_cnt_o) : retry_cnt_o;
      errc_n  = err_s ? sat_inc16(error_cnt_o) : error_cnt_o;
    end
  end

  // FSM state, shared timer and error window registers.
  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      state_r <= DISABLED;
      timer_r <= {TIMER_W{1'b0}};
      win_r   <= 16'd0;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      win_r   <= win_n;
    end
  end

  // Outputs decoded from the next state so they are valid in a state's first cycle.
  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      general_reset_o   <= 1'b1;
      manual_reset_rx_o <= 1'b0;
      sfp_txdisable_o   <= 1'b1;
      link_up_o         <= 1'b0;
      retry_cnt_o       <= 8'd0;
      error_cnt_o       <= 16'd0;
    end else begin
      general_reset_o   <= (state_n == DISABLED) || (state_n == GEN_RESET);
      manual_reset_rx_o <= (state_n == RX_RESET);
      sfp_txdisable_o   <= (state_n == DISABLED);
      link_up_o         <= (state_n == LINK_UP);
      retry_cnt_o       <= retry_n;
      error_cnt_o       <= errc_n;
    end
  end

  assign state_o = state_r;

endmodule

// File: tb/tb_gbt_link_supervisor.sv
// Scoreboard bench for gbt_link_supervisor: stimulus pushes expected state
// transitions (with dwell and counters), a monitor checks each one as it occurs.
module tb_gbt_link_supervisor;

  localparam int RC = 4, TXT = 100, RXT = 100, BO = 20, LF = 4, ET = 3, EW = 50;
  localparam logic [2:0] S_DIS = 3'd0, S_GEN = 3'd1, S_WTX = 3'd2, S_RXR = 3'd3,
                         S_WRX = 3'd4, S_UP = 3'd5, S_BO = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable, tx_rdy, rx_rdy, lnk_rdy, rx_err, clr;
  logic general_reset, manual_reset_rx, sfp_txdisable, link_up;
  logic [2:0]  state;
  logic [7:0]  retry;
  logic [15:0] errc;

  gbt_link_supervisor_if los_bus ();

  gbt_link_supervisor #(
    .G_RESET_CYCLES(RC), .G_TX_TIMEOUT(TXT), .G_RX_TIMEOUT(RXT), .G_BACKOFF(BO),
    .G_LOS_FILTER(LF), .G_ERR_THRESHOLD(ET), .G_ERR_WINDOW(EW)
  ) dut (
    .clk_ik(clk), .rst_ir(rst), .enable_i(enable), .sfp_los_i(los_bus.los_raw),
    .gbttx_ready_i(tx_rdy), .gbtrx_ready_i(rx_rdy), .link_ready_i(lnk_rdy),
    .rx_errordetected_i(rx_err), .clr_cnt_i(clr),
    .general_reset_o(general_reset), .manual_reset_rx_o(manual_reset_rx),
    .sfp_txdisable_o(sfp_txdisable), .link_up_o(link_up), .state_o(state),
    .retry_cnt_o(retry), .error_cnt_o(errc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    int          dwell;
    logic [7:0]  retry;
    logic [15:0] errc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_retry = 0;
  int m_err = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input int dwell, input bit retry_evt);
    exp_t e;
    if (retry_evt) m_retry = (m_retry + 1 > 255) ? 255 : m_retry + 1;
    e.st = st; e.dwell = dwell; e.retry = 8'(m_retry); e.errc = 16'(m_err);
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n = 0;
    while (state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state !== st) begin
      checks++; errors++;
      $display("FAIL wait_state_%0d timeout got state %0d", st, state);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain timeout got %0d pending want 0", q.size());
    end
  endtask

  // Monitor: every state change must match the next expected transition.
  initial begin
    logic [2:0] prev;
    int dwell;
    exp_t e;
    bit ok;
    wait (rst == 1'b0);
    @(negedge clk);
    prev = state;
    dwell = 1;
    forever begin
      @(negedge clk);
      if (state !== prev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change got %0d from %0d want none", state, prev);
        end else begin
          e = q.pop_front();
          ok = (state === e.st) && (retry === e.retry) && (errc === e.errc) &&
               (link_up === (e.st == S_UP)) && (general_reset === (e.st <= S_GEN)) &&
               (manual_reset_rx === (e.st == S_RXR)) && (sfp_txdisable === (e.st == S_DIS));
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL trans_to_%0d got st=%0d retry=%0d err=%0d up=%b gr=%b mr=%b txd=%b want st=%0d retry=%0d err=%0d",
                     e.st, state, retry, errc, link_up, general_reset, manual_reset_rx,
                     sfp_txdisable, e.st, e.retry, e.errc);
          end
          if (e.dwell >= 0) chk($sformatf("dwell_in_%0d", prev), dwell, e.dwell);
        end
        prev = state;
        dwell = 1;
      end else begin
        dwell++;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s;
    enable = 1'b0; tx_rdy = 1'b0; rx_rdy = 1'b0; lnk_rdy = 1'b0;
    rx_err = 1'b0; clr = 1'b0; los_bus.los_raw = 1'b0;

    cyc(3);
    chk("rst_state", state, S_DIS);
    chk("rst_general_reset", general_reset, 1);
    chk("rst_txdisable", sfp_txdisable, 1);
    chk("rst_link_up", link_up, 0);
    chk("rst_manual_rx", manual_reset_rx, 0);
    chk("rst_retry", retry, 0);
    chk("rst_errc", errc, 0);
    rst = 1'b0;
    cyc(10);
    chk("idle_disabled", state, S_DIS);

    // Bring-up: tx ready at cycle 10, rx+link ready at cycle 30.
    push_exp(S_GEN, -1, 0); push_exp(S_WTX, RC, 0); push_exp(S_RXR, -1, 0);
    push_exp(S_WRX, RC, 0); push_exp(S_UP, -1, 0);
    enable = 1'b1;
    cyc(10); tx_rdy = 1'b1;
    cyc(20); rx_rdy = 1'b1; lnk_rdy = 1'b1;
    wait_state(S_UP, 200);
    cyc(2);
    chk("bringup_retry", retry, 0);

    // LOS shorter than the filter length is ignored.
    g = $urandom_range(1, LF - 1);
    los_bus.los_raw = 1'b1; cyc(g); los_bus.los_raw = 1'b0;
    cyc(12);
    chk("los_glitch_state", state, S_UP);
    chk("los_glitch_link_up", link_up, 1);

    // LOS of exactly the filter length drops the link and retries.
    push_exp(S_BO, -1, 1); push_exp(S_GEN, BO, 0); push_exp(S_WTX, RC, 0);
    push_exp(S_RXR, -1, 0); push_exp(S_WRX, RC, 0); push_exp(S_UP, -1, 0);
    los_bus.los_raw = 1'b1; cyc(LF); los_bus.los_raw = 1'b0;
    wait_state(S_BO, 20);
    wait_state(S_UP, 200);

    // Threshold errors inside one window force an RX reset.
    cyc(5);
    m_err += ET;
    push_exp(S_RXR, -1, 1); push_exp(S_WRX, RC, 0); push_exp(S_UP, -1, 0);
    rx_err = 1'b1; cyc(ET); rx_err = 1'b0;
    wait_state(S_UP, 50);

    // Sparse errors never reach the threshold in any window.
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(25, 40);
      cyc(s); rx_err = 1'b1; cyc(1); rx_err = 1'b0;
      m_err++;
    end
    cyc(3);
    chk("sparse_err_state", state, S_UP);
    chk("sparse_err_count", errc, m_err);

    // TX timeout, then disable coinciding with the second timeout.
    push_exp(S_DIS, -1, 0);
    enable = 1'b0;
    wait_state(S_DIS, 5);
    tx_rdy = 1'b0;
    push_exp(S_GEN, -1, 0); push_exp(S_WTX, RC, 0); push_exp(S_BO, TXT, 1);
    push_exp(S_GEN, BO, 0); push_exp(S_WTX, RC, 0); push_exp(S_DIS, TXT, 0);
    enable = 1'b1;
    wait_state(S_BO, 200);
    wait_state(S_GEN, 50);
    wait_state(S_WTX, 20);
    cyc(TXT - 1);
    enable = 1'b0;
    wait_state(S_DIS, 5);
    cyc(2);
    chk("priority_retry", retry, m_retry);

    // Saturation: hold LOS so BACKOFF is re-entered 300 times.
    tx_rdy = 1'b1;
    push_exp(S_GEN, -1, 0); push_exp(S_WTX, RC, 0); push_exp(S_RXR, -1, 0);
    push_exp(S_WRX, RC, 0); push_exp(S_UP, -1, 0);
    enable = 1'b1;
    wait_state(S_UP, 100);
    push_exp(S_BO, -1, 1);
    for (int i = 1; i < 300; i++) begin
      push_exp(S_GEN, BO, 0);
      push_exp(S_BO, 1, 1);
    end
    los_bus.los_raw = 1'b1;
    drain(8000);
    push_exp(S_DIS, -1, 0);
    enable = 1'b0;
    wait_state(S_DIS, 5);
    cyc(2);
    chk("retry_saturated", retry, 255);

    // Clear coinciding with a retry increment wins.
    los_bus.los_raw = 1'b0;
    cyc(10);
    tx_rdy = 1'b0;
    push_exp(S_GEN, -1, 0); push_exp(S_WTX, RC, 0);
    enable = 1'b1;
    wait_state(S_WTX, 20);
    cyc(TXT - 1);
    m_retry = 0; m_err = 0;
    push_exp(S_BO, TXT, 0);
    clr = 1'b1; cyc(1); clr = 1'b0;
    push_exp(S_GEN, BO, 0);
    wait_state(S_GEN, 40);
    push_exp(S_DIS, -1, 0);
    enable = 1'b0;
    wait_state(S_DIS, 5);
    cyc(2);
    chk("clr_retry", retry, 0);
    chk("clr_errc", errc, 0);

    // Reset mid-operation discards counters immediately.
    push_exp(S_GEN, -1, 0); push_exp(S_WTX, RC, 0); push_exp(S_BO, TXT, 1);
    enable = 1'b1;
    wait_state(S_BO, 150);
    cyc(3);
    chk("pre_reset_retry", retry, 1);
    m_retry = 0; m_err = 0;
    push_exp(S_DIS, -1, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", state, S_DIS);
    chk("midrst_retry", retry, 0);
    chk("midrst_general_reset", general_reset, 1);
    enable = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    drain(5);
    chk("final_state", state, S_DIS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
